// File: rtl/mmv_demux_pkg.sv
// Shared constants and the address decoder for the MemoryMapped demultiplexer.
package mmv_demux_pkg;

  localparam int DEF_AWIDTH  = 8;
  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_SLAVES  = 3;
  localparam int DEF_RDPENDS = 2;

  // Width of a target index; value DEF_SLAVES is the local error target.
  localparam int SELW = $clog2(DEF_SLAVES + 1);

  localparam logic [DEF_SLAVES-1:0][DEF_AWIDTH-1:0] DEF_BASE = {8'h80, 8'h40, 8'h00};
  localparam logic [DEF_SLAVES-1:0][DEF_AWIDTH-1:0] DEF_MASK = {3{8'hC0}};

  // Returns the lowest-index slave whose masked base matches addr,
  // or DEF_SLAVES when no slave claims the address.
  function automatic logic [SELW-1:0] decode_sel(
    input logic [DEF_AWIDTH-1:0]                  addr,
    input logic [DEF_SLAVES-1:0][DEF_AWIDTH-1:0]  base,
    input logic [DEF_SLAVES-1:0][DEF_AWIDTH-1:0]  mask
  );
    logic [SELW-1:0] sel;
    sel = SELW'(DEF_SLAVES);
    // Scan from the top so the lowest matching index is the last one written.
    for (int i = DEF_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask[i]) == base[i]) begin
        sel = SELW'(i);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmv_demux_rdtrack.sv
// Outstanding-read tracker: counts pending reads, remembers which target
// owns them, stalls reads that would break ordering or overflow, and
// muxes the returning read data back to the master.
module mmv_demux_rdtrack
  import mmv_demux_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int SLAVES  = DEF_SLAVES,
  parameter int RDPENDS = DEF_RDPENDS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_rreq_i,
  input  logic [SELW-1:0]                sel_i,
  input  logic                           sel_busy_i,
  input  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat_i,
  input  logic [SLAVES-1:0]              m_rval_i,
  output logic                           rd_go_o,
  output logic                           s_busy_o,
  output logic                           s_rval_o,
  output logic [DWIDTH-1:0]              s_rdat_o
);

  localparam int CW = $clog2(RDPENDS + 1);

  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [SELW-1:0] cur_sel_q,  cur_sel_d;
  logic            err_rval_q, err_rval_d;
  logic            pend_nz, ostall, fstall, accept;

  // Stall decisions and response muxing, all from registered tracker state.
  always_comb begin
    pend_nz  = (pend_cnt_q != CW'(0));
    ostall   = s_rreq_i & pend_nz & (sel_i != cur_sel_q);
    fstall   = s_rreq_i & (pend_cnt_q == CW'(RDPENDS));
    rd_go_o  = ~ostall & ~fstall;
    s_busy_o = ostall | fstall | sel_busy_i;
    accept   = s_rreq_i & ~s_busy_o;
    if (cur_sel_q < SELW'(SLAVES)) begin
      s_rval_o = m_rval_i[cur_sel_q] & pend_nz;
      s_rdat_o = m_rdat_i[cur_sel_q];
    end else begin
      s_rval_o = err_rval_q;
      s_rdat_o = '0;
    end
  end

  // Next-state for the pending count, owning target and local error response.
  always_comb begin
    if (accept) begin
      cur_sel_d = sel_i;
    end else begin
      cur_sel_d = cur_sel_q;
    end
    err_rval_d = accept & (sel_i == SELW'(SLAVES));
    case ({accept, s_rval_o})
      2'b10:   pend_cnt_d = pend_cnt_q + CW'(1);
      2'b01:   pend_cnt_d = pend_cnt_q - CW'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  // Tracker registers; reset drops every outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt_q <= CW'(0);
      cur_sel_q  <= SELW'(0);
      err_rval_q <= 1'b0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      cur_sel_q  <= cur_sel_d;
      err_rval_q <= err_rval_d;
    end
  end

endmodule

// File: rtl/mmv_demultiplexer.sv
// One MemoryMapped master fanned out to SLAVES slaves by address decode.
// Requests and responses pass through combinationally; unmapped reads
// complete locally one cycle later with zero data.
module mmv_demultiplexer
  import mmv_demux_pkg::*;
#(
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int SLAVES  = DEF_SLAVES,
  parameter int RDPENDS = DEF_RDPENDS,
  parameter logic [SLAVES-1:0][AWIDTH-1:0] BASE = DEF_BASE,
  parameter logic [SLAVES-1:0][AWIDTH-1:0] MASK = DEF_MASK
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic [AWIDTH-1:0]              s_addr,
  input  logic                           s_wreq,
  input  logic [DWIDTH-1:0]              s_wdat,
  input  logic                           s_rreq,
  output logic [DWIDTH-1:0]              s_rdat,
  output logic                           s_rval,
  output logic                           s_busy,
  output logic [SLAVES-1:0][AWIDTH-1:0]  m_addr,
  output logic [SLAVES-1:0]              m_wreq,
  output logic [SLAVES-1:0][DWIDTH-1:0]  m_wdat,
  output logic [SLAVES-1:0]              m_rreq,
  input  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat,
  input  logic [SLAVES-1:0]              m_rval,
  input  logic [SLAVES-1:0]              m_busy
);

  logic [SELW-1:0] sel;
  logic            sel_busy;
  logic            rd_go;

  // Address decode and the stall contributed by the selected slave.
  always_comb begin
    sel = decode_sel(s_addr, BASE, MASK);
    if (sel < SELW'(SLAVES)) begin
      sel_busy = m_busy[sel];
    end else begin
      sel_busy = 1'b0;
    end
  end

  // Request fan-out: address and data go everywhere, strobes only to the target.
  always_comb begin
    for (int i = 0; i < SLAVES; i++) begin
      m_addr[i] = s_addr;
      m_wdat[i] = s_wdat;
      m_wreq[i] = s_wreq & (sel == SELW'(i));
      m_rreq[i] = s_rreq & (sel == SELW'(i)) & rd_go;
    end
  end

  mmv_demux_rdtrack #(
    .DWIDTH  (DWIDTH),
    .SLAVES  (SLAVES),
    .RDPENDS (RDPENDS)
  ) u_rdtrack (
    .clk        (clk),
    .reset      (reset),
    .s_rreq_i   (s_rreq),
    .sel_i      (sel),
    .sel_busy_i (sel_busy),
    .m_rdat_i   (m_rdat),
    .m_rval_i   (m_rval),
    .rd_go_o    (rd_go),
    .s_busy_o   (s_busy),
    .s_rval_o   (s_rval),
    .s_rdat_o   (s_rdat)
  );

endmodule

// File: tb/tb_mmv_demultiplexer.sv
// Self-checking bench for mmv_demultiplexer: directed scenarios followed by
// random traffic, compared against an in-order transaction model.
module tb_mmv_demultiplexer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int RP = 2;
  localparam int RDDELAY = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [AW-1:0]          s_addr;
  logic                   s_wreq;
  logic [DW-1:0]          s_wdat;
  logic                   s_rreq;
  logic [DW-1:0]          s_rdat;
  logic                   s_rval;
  logic                   s_busy;
  logic [NS-1:0][AW-1:0]  m_addr;
  logic [NS-1:0]          m_wreq;
  logic [NS-1:0][DW-1:0]  m_wdat;
  logic [NS-1:0]          m_rreq;
  logic [NS-1:0][DW-1:0]  m_rdat;
  logic [NS-1:0]          m_rval;
  logic [NS-1:0]          m_busy;

  always #5 clk = ~clk;

  mmv_demultiplexer dut (
    .reset  (reset),
    .clk    (clk),
    .s_addr (s_addr),
    .s_wreq (s_wreq),
    .s_wdat (s_wdat),
    .s_rreq (s_rreq),
    .s_rdat (s_rdat),
    .s_rval (s_rval),
    .s_busy (s_busy),
    .m_addr (m_addr),
    .m_wreq (m_wreq),
    .m_wdat (m_wdat),
    .m_rreq (m_rreq),
    .m_rdat (m_rdat),
    .m_rval (m_rval),
    .m_busy (m_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address map as ranges: 00-3F slave 0, 40-7F slave 1, 80-BF slave 2, rest unmapped.
  function automatic int ref_sel(input logic [AW-1:0] a);
    if (a < 8'h40) return 0;
    else if (a < 8'h80) return 1;
    else if (a < 8'hC0) return 2;
    else return NS;
  endfunction

  // Content each slave returns for an address.
  function automatic logic [DW-1:0] slave_data(input int s, input logic [AW-1:0] a);
    return DW'(a * 8'd3) ^ DW'(8'h1D * (s + 1));
  endfunction

  typedef struct {
    int            tgt;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t pq[$];   // reads the master is still owed, oldest first
  rd_t sq[$];   // reads the slaves are working on (survive a bench reset)

  int            cyc = 0;
  bit            busy_en = 1'b0;
  bit            ev_acc, ev_rval;
  int            ev_sel;
  logic [AW-1:0] ev_addr;
  logic [NS-1:0] ev_sacc;

  // Compare DUT outputs mid-cycle against the model and record this cycle's events.
  initial forever begin
    int  sel;
    bit  stall, exp_busy, exp_rval;
    logic [NS-1:0] exp_wreq, exp_rreq;
    @(negedge clk);
    ev_sacc = m_rreq & ~m_busy;
    ev_addr = s_addr;
    if (reset) begin
      ev_acc  = 1'b0;
      ev_rval = 1'b0;
    end else begin
      sel   = ref_sel(s_addr);
      stall = s_rreq && ((pq.size() != 0 && pq[0].tgt != sel) || pq.size() == RP);
      exp_busy = stall || (sel < NS && m_busy[sel]);
      exp_wreq = (s_wreq && sel < NS) ? NS'(1 << sel) : '0;
      exp_rreq = (s_rreq && sel < NS && !stall) ? NS'(1 << sel) : '0;
      exp_rval = (pq.size() != 0) && (pq[0].due == cyc);
      check("wr_rd_excl", 32'(s_wreq & s_rreq), 32'd0);
      check("s_busy", 32'(s_busy), 32'(exp_busy));
      check("m_wreq", 32'(m_wreq), 32'(exp_wreq));
      check("m_rreq", 32'(m_rreq), 32'(exp_rreq));
      check("m_addr", 32'(m_addr), 32'({NS{s_addr}}));
      check("m_wdat", 32'(m_wdat), 32'({NS{s_wdat}}));
      check("s_rval", 32'(s_rval), 32'(exp_rval));
      if (exp_rval) check("s_rdat", 32'(s_rdat), 32'(pq[0].data));
      ev_acc  = s_rreq && !exp_busy;
      ev_sel  = sel;
      ev_rval = exp_rval;
    end
  end

  // Advance the model at each edge and drive the slave responses just after it.
  initial begin
    m_rval = '0;
    m_rdat = '0;
    m_busy = '0;
    forever begin
      rd_t e;
      @(posedge clk);
      if (reset) begin
        pq.delete();
      end else begin
        if (ev_rval) pq.pop_front();
        if (ev_acc) begin
          e.tgt  = ev_sel;
          e.data = (ev_sel < NS) ? slave_data(ev_sel, ev_addr) : '0;
          e.due  = (ev_sel < NS) ? cyc + RDDELAY : cyc + 1;
          pq.push_back(e);
        end
      end
      for (int i = sq.size() - 1; i >= 0; i--) if (sq[i].due == cyc) sq.delete(i);
      for (int i = 0; i < NS; i++) begin
        if (ev_sacc[i]) begin
          e.tgt  = i;
          e.data = slave_data(i, ev_addr);
          e.due  = cyc + RDDELAY;
          sq.push_back(e);
        end
      end
      cyc++;
      #1;
      m_rval = '0;
      for (int i = 0; i < NS; i++) m_rdat[i] = DW'($urandom);
      foreach (sq[j]) begin
        if (sq[j].due == cyc) begin
          m_rval[sq[j].tgt] = 1'b1;
          m_rdat[sq[j].tgt] = sq[j].data;
        end
      end
      m_busy = busy_en ? NS'($urandom) : '0;
    end
  end

  // Present one request (0 idle, 1 write, 2 read) and hold it until accepted.
  task automatic do_op(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    int k;
    s_wreq = (kind == 1);
    s_rreq = (kind == 2);
    s_addr = a;
    s_wdat = d;
    k = 0;
    do begin
      @(negedge clk);
      done = (kind == 0) || !s_busy;
      k++;
      @(posedge clk);
      #1;
    end while (!done && k < 64);
    check("accepted", 32'(done), 32'd1);
    s_wreq = 1'b0;
    s_rreq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_op(0, s_addr, s_wdat);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    s_addr = '0;
    s_wdat = '0;
    s_wreq = 1'b0;
    s_rreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    do_op(1, 8'h45, 8'hA5);                       // write routed to slave 1
    do_op(2, 8'h10, 8'h00); do_op(2, 8'h12, 8'h00); idle(8);   // back-to-back reads
    do_op(2, 8'h10, 8'h00); do_op(2, 8'h80, 8'h00); idle(10);  // order stall
    repeat (3) do_op(2, 8'h50, 8'h00); idle(10);  // full stall
    do_op(2, 8'hC0, 8'h00); do_op(1, 8'hC4, 8'h3C); idle(3);   // unmapped accesses
    do_op(2, 8'h41, 8'h00); do_op(2, 8'h42, 8'h00);            // reset with reads pending
    pulse_reset();
    idle(1);
    do_op(2, 8'h00, 8'h00); idle(8);

    busy_en = 1'b1;
    repeat (400) do_op(int'($urandom_range(0, 2)), AW'($urandom), DW'($urandom));
    busy_en = 1'b0;
    s_addr = '0;

    k = 0;
    while (pq.size() != 0 && k < 200) begin
      idle(1);
      k++;
    end
    check("drain", 32'(pq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
